pipe_hazard_ctrl: RTL

- Second-generation hazard/stall/flush controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Keeps register-operand forwarding, load-use and branch-compare stalls, and divider stalls from the current hazard unit.
- Adds parametrised register/HILO forwarding and handshake-based stalls for instruction and data memory (req / data_ok).
- Adds a fetch-discard state machine for redirects that occur while a fetch is outstanding, plus a saturating stall-cycle counter.

---
 rtl/mips_pipe_pkg.sv | 27 ++
 rtl/pipe_hazard_ctrl_if.sv | 38 +++
 rtl/mem_wait_fsm.sv | 36 +++
 rtl/pipe_hazard_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared encodings for the MIPS pipeline hazard controller.
// Forwarding selects, memory-handshake FSM states and default widths.
package mips_pipe_pkg;

  localparam int unsigned REG_AW_DEF = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

  typedef enum logic [1:0] {
    I_IDLE    = 2'b00,
    I_WAIT    = 2'b01,
    I_DISCARD = 2'b10
  } inst_state_e;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_WAIT = 1'b1
  } data_state_e;

  // M wins over W when both stages write the same register.
  function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
    return hit_m ? FWD_M : (hit_w ? FWD_W : FWD_RF);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller: stage registers, handshakes,
// and the forward/stall/flush controls returned to the datapath.
interface pipe_hazard_ctrl_if
  import mips_pipe_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
);
  logic [REG_AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic branchD, regwriteE, memtoregE, div_stallE;
  logic regwriteM, memtoregM, regwriteW, write_hiloM, write_hiloW;
  logic redirectM, excM;
  logic inst_req, inst_data_ok, data_req, data_data_ok;
  logic       forwardaD, forwardbD;
  logic [1:0] forwardaE, forwardbE, forward_hiloE;
  logic stallF, stallD, stallE, stallM, stallW;
  logic flushF, flushD, flushE, flushM, flushW;
  logic inst_discard;

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    input  branchD, regwriteE, memtoregE, div_stallE,
    input  regwriteM, memtoregM, regwriteW, write_hiloM, write_hiloW,
    input  redirectM, excM, inst_req, inst_data_ok, data_req, data_data_ok,
    output forwardaD, forwardbD, forwardaE, forwardbE, forward_hiloE,
    output stallF, stallD, stallE, stallM, stallW,
    output flushF, flushD, flushE, flushM, flushW, inst_discard
  );

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    output branchD, regwriteE, memtoregE, div_stallE,
    output regwriteM, memtoregM, regwriteW, write_hiloM, write_hiloW,
    output redirectM, excM, inst_req, inst_data_ok, data_req, data_data_ok,
    input  forwardaD, forwardbD, forwardaE, forwardbE, forward_hiloE,
    input  stallF, stallD, stallE, stallM, stallW,
    input  flushF, flushD, flushE, flushM, flushW, inst_discard
  );
endinterface

// File: rtl/mem_wait_fsm.sv
// Tracks one outstanding memory request; with DISCARD_EN it remembers that the
// in-flight response belongs to a squashed fetch and must be dropped.
module mem_wait_fsm
  import mips_pipe_pkg::*;
#(
  parameter bit DISCARD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_data_ok,
  input  logic        i_abort,
  output inst_state_e o_state
);

  inst_state_e r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= I_IDLE;
    end else begin
      unique case (r_state)
        I_IDLE:    if (i_req && !i_data_ok) r_state <= I_WAIT;
        I_WAIT: begin
          if (i_data_ok)                   r_state <= I_IDLE;
          else if (DISCARD_EN && i_abort)  r_state <= I_DISCARD;
        end
        I_DISCARD: if (i_data_ok) r_state <= I_IDLE;
        default:   r_state <= I_IDLE;
      endcase
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and flush controller for the 5-stage pipeline, including
// memory handshake waits, fetch discard after redirects and a stall counter.
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus,
  output logic [CNT_W-1:0]   stall_cycles
);

  logic        w_nz_rsd, w_nz_rtd, w_nz_rse, w_nz_rte, w_nz_wre, w_nz_wrm;
  logic        w_lwstall, w_brstall, w_iwait, w_dwait, w_abort;
  inst_state_e w_i_state, w_d_state;
  logic [CNT_W-1:0] r_stall_cycles;

  assign w_nz_rsd = bus.rsD != REG_AW'(0);
  assign w_nz_rtd = bus.rtD != REG_AW'(0);
  assign w_nz_rse = bus.rsE != REG_AW'(0);
  assign w_nz_rte = bus.rtE != REG_AW'(0);
  assign w_nz_wre = bus.writeregE != REG_AW'(0);
  assign w_nz_wrm = bus.writeregM != REG_AW'(0);

  assign bus.forwardaE = fwd_sel(w_nz_rse && bus.regwriteM && bus.writeregM == bus.rsE,
                                 w_nz_rse && bus.regwriteW && bus.writeregW == bus.rsE);
  assign bus.forwardbE = fwd_sel(w_nz_rte && bus.regwriteM && bus.writeregM == bus.rtE,
                                 w_nz_rte && bus.regwriteW && bus.writeregW == bus.rtE);
  assign bus.forward_hiloE = fwd_sel(bus.write_hiloM, bus.write_hiloW);
  assign bus.forwardaD = w_nz_rsd && bus.regwriteM && bus.writeregM == bus.rsD;
  assign bus.forwardbD = w_nz_rtd && bus.regwriteM && bus.writeregM == bus.rtD;

  assign w_lwstall = bus.memtoregE && w_nz_rte &&
                     (bus.rtE == bus.rsD || bus.rtE == bus.rtD);
  assign w_brstall = bus.branchD &&
      ((bus.regwriteE && w_nz_wre && (bus.writeregE == bus.rsD || bus.writeregE == bus.rtD)) ||
       (bus.memtoregM && w_nz_wrm && (bus.writeregM == bus.rsD || bus.writeregM == bus.rtD)));

  // A data wait freezes M, so a redirect/exception there is not yet acted on.
  assign w_dwait = (w_d_state == I_WAIT) && !bus.data_data_ok;
  assign w_abort = (bus.redirectM || bus.excM) && !w_dwait;
  assign w_iwait = ((w_i_state == I_WAIT) && !bus.inst_data_ok) || (w_i_state == I_DISCARD);
  assign bus.inst_discard = !rst && bus.inst_data_ok &&
      ((w_i_state == I_DISCARD) || ((w_i_state == I_WAIT) && w_abort));

  mem_wait_fsm #(.DISCARD_EN(1'b1)) u_inst_fsm (
    .clk       (clk),
    .rst       (rst),
    .i_req     (bus.inst_req),
    .i_data_ok (bus.inst_data_ok),
    .i_abort   (w_abort),
    .o_state   (w_i_state)
  );

  mem_wait_fsm #(.DISCARD_EN(1'b0)) u_data_fsm (
    .clk       (clk),
    .rst       (rst),
    .i_req     (bus.data_req),
    .i_data_ok (bus.data_data_ok),
    .i_abort   (1'b0),
    .o_state   (w_d_state)
  );

  always_comb begin
    {bus.stallF, bus.stallD, bus.stallE, bus.stallM, bus.stallW} = '0;
    {bus.flushF, bus.flushD, bus.flushE, bus.flushM, bus.flushW} = '0;
    if (rst) begin
      {bus.flushF, bus.flushD, bus.flushE, bus.flushM, bus.flushW} = '1;
    end else if (w_dwait) begin
      {bus.stallF, bus.stallD, bus.stallE, bus.stallM} = '1;
      bus.flushW = 1'b1;
    end else if (bus.excM) begin
      {bus.flushF, bus.flushD, bus.flushE, bus.flushM, bus.flushW} = '1;
    end else if (bus.redirectM) begin
      {bus.flushF, bus.flushD, bus.flushE} = '1;
    end else begin
      if (bus.div_stallE) begin
        {bus.stallF, bus.stallD, bus.stallE} = '1;
        bus.flushM = 1'b1;
      end else if (w_lwstall || w_brstall) begin
        {bus.stallF, bus.stallD} = '1;
        bus.flushE = 1'b1;
      end
      // A fetch bubble goes into D unless D itself is being held.
      if (w_iwait) begin
        bus.stallF = 1'b1;
        bus.flushD = !bus.stallD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (bus.stallF && !(&r_stall_cycles)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule
